// File: rtl/config_chain_loader_if.sv
// rtl/config_chain_loader_if.sv - bitstream word handshake between source and config_chain_loader
interface config_chain_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - streams bitstream words LSB-first into a tile config shift chain
// Optional trailing CRC-8 check enabled by defining CONFIG_LOADER_CRC_EN.
module config_chain_loader #(
    parameter int CHAIN_LENGTH = 24,
    parameter int WORD_WIDTH   = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    config_chain_loader_if.slave  word_if,
    output logic                  config_in,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BW = $clog2(CHAIN_LENGTH + 1);
    localparam int SW = $clog2(WORD_WIDTH + 1);
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

`ifdef CONFIG_LOADER_CRC_EN
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SHIFT, CRC_FETCH, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SHIFT, DONE} state_t;
`endif

    state_t                state, state_next;
    logic [CW-1:0]         clear_cnt, clear_cnt_next;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic [SW-1:0]         shift_cnt, shift_cnt_next;
    logic [WORD_WIDTH-1:0] sr, sr_next;
    logic                  enable_q, data_q, chain_nreset_q;
    logic                  accept;

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc, crc_next, expected, expected_next;
    logic       error_q, error_next;
    assign word_if.word_ready = (state == FETCH) || (state == CRC_FETCH);
    assign error = error_q;
`else
    assign word_if.word_ready = (state == FETCH);
    assign error = 1'b0;
`endif

    assign accept        = word_if.word_valid & word_if.word_ready;
    assign config_enable = enable_q;
    assign config_in     = data_q;
    assign config_nreset = chain_nreset_q;
    assign busy          = (state != IDLE) && (state != DONE);
    assign done          = (state == DONE);

    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        bit_cnt_next   = bit_cnt;
        shift_cnt_next = shift_cnt;
        sr_next        = sr;
`ifdef CONFIG_LOADER_CRC_EN
        crc_next       = crc;
        expected_next  = expected;
        error_next     = error_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = CLEAR;
                    clear_cnt_next = CW'(CLEAR_CYCLES - 1);
`ifdef CONFIG_LOADER_CRC_EN
                    crc_next       = 8'h00;
                    error_next     = 1'b0;
`endif
                end
            end
            CLEAR: begin
                if (clear_cnt == '0) begin
                    state_next   = FETCH;
                    bit_cnt_next = BW'(CHAIN_LENGTH);
                end else begin
                    clear_cnt_next = clear_cnt - 1'b1;
                end
            end
            FETCH: begin
                if (accept) begin
                    sr_next        = word_if.word_data;
                    shift_cnt_next = (32'(bit_cnt) >= WORD_WIDTH) ? SW'(WORD_WIDTH) : SW'(bit_cnt);
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                sr_next        = sr >> 1;
                shift_cnt_next = shift_cnt - 1'b1;
                bit_cnt_next   = bit_cnt - 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                crc_next       = {crc[6:0], 1'b0} ^ ((crc[7] ^ sr[0]) ? 8'h07 : 8'h00);
`endif
                // Upper bits of a short final word are never shifted; they fall off with sr.
                if (shift_cnt == SW'(1)) begin
`ifdef CONFIG_LOADER_CRC_EN
                    state_next = (bit_cnt == BW'(1)) ? CRC_FETCH : FETCH;
`else
                    state_next = (bit_cnt == BW'(1)) ? DONE : FETCH;
`endif
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CRC_FETCH: begin
                if (accept) begin
                    expected_next = word_if.word_data[7:0];
                    state_next    = CHECK;
                end
            end
            CHECK: begin
                error_next = (crc != expected);
                state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state          <= IDLE;
            clear_cnt      <= '0;
            bit_cnt        <= '0;
            shift_cnt      <= '0;
            sr             <= '0;
            enable_q       <= 1'b0;
            data_q         <= 1'b0;
            chain_nreset_q <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc            <= 8'h00;
            expected       <= 8'h00;
            error_q        <= 1'b0;
`endif
        end else begin
            state          <= state_next;
            clear_cnt      <= clear_cnt_next;
            bit_cnt        <= bit_cnt_next;
            shift_cnt      <= shift_cnt_next;
            sr             <= sr_next;
            // Chain outputs are registered from next-state so they line up with the SHIFT cycle.
            enable_q       <= (state_next == SHIFT);
            data_q         <= (state_next == SHIFT) & sr_next[0];
            chain_nreset_q <= (state_next != CLEAR);
`ifdef CONFIG_LOADER_CRC_EN
            crc            <= crc_next;
            expected       <= expected_next;
            error_q        <= error_next;
`endif
        end
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader against a chain/stream model
module tb_config_chain_loader;
    localparam int W   = 8;
    localparam int CLR = 2;
    localparam int LA  = 24;
    localparam int LB  = 20;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int CRC_X = 1;
`else
    localparam int CRC_X = 0;
`endif

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic         wv = 1'b0;
    logic [W-1:0] wd = '0;

    always #5 clock = ~clock;

    config_chain_loader_if #(.WORD_WIDTH(W)) if_a ();
    config_chain_loader_if #(.WORD_WIDTH(W)) if_b ();
    assign if_a.word_data  = wd;
    assign if_a.word_valid = wv;
    assign if_b.word_data  = wd;
    assign if_b.word_valid = wv;

    logic cin_a, en_a, cnr_a, busy_a, done_a, err_a;
    logic cin_b, en_b, cnr_b, busy_b, done_b, err_b;

    config_chain_loader #(.CHAIN_LENGTH(LA), .WORD_WIDTH(W), .CLEAR_CYCLES(CLR)) dut_a (
        .clock(clock), .nreset(nreset), .start(start_a), .word_if(if_a),
        .config_in(cin_a), .config_enable(en_a), .config_nreset(cnr_a),
        .busy(busy_a), .done(done_a), .error(err_a));

    config_chain_loader #(.CHAIN_LENGTH(LB), .WORD_WIDTH(W), .CLEAR_CYCLES(CLR)) dut_b (
        .clock(clock), .nreset(nreset), .start(start_b), .word_if(if_b),
        .config_in(cin_b), .config_enable(en_b), .config_nreset(cnr_b),
        .busy(busy_b), .done(done_b), .error(err_b));

    // Downstream tile chains: bits enter at the head and travel toward index 0.
    logic [LA-1:0] chain_a = '0;
    logic [LB-1:0] chain_b = '0;
    always @(posedge clock) begin
        if (!cnr_a) chain_a <= '0;
        else if (en_a) chain_a <= {cin_a, chain_a[LA-1:1]};
        if (!cnr_b) chain_b <= '0;
        else if (en_b) chain_b <= {cin_b, chain_b[LB-1:1]};
    end

    int vectors = 0, miscompares = 0;
    logic [7:0] words[8];
    logic en_log[64], cin_log[64], cnr_log[64], done_log[64];
    int hs_cyc[8];
    int hs_n, rdy_cnt, stall_seen, stall_en, en_cnt, done_cyc;
    logic err_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stream_val(input int len);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = words[i / 8][i % 8];
        return v;
    endfunction

    function automatic logic [7:0] crc_of(input int len);
        logic [7:0] c;
        logic b;
        c = 8'h00;
        for (int i = 0; i < len; i++) begin
            b = words[i / 8][i % 8];
            c = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic prep(input int len, input bit flip);
        words[(len + W - 1) / W] = crc_of(len) ^ {7'd0, flip};
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    endtask

    task automatic run_load(input bit sel, input int stall_at, input int stall_len,
                            input int rst_at, input int sp1, input int sp2);
        int idx;
        logic rdy, en, cin, cnr, bsy, dn, er;
        idx = 0; hs_n = 0; rdy_cnt = 0; stall_seen = 0; stall_en = 0; en_cnt = 0;
        done_cyc = -1; err_at_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (sel) start_b = (c == 0) || (c == sp1) || (c == sp2);
            else     start_a = (c == 0) || (c == sp1) || (c == sp2);
            nreset = (c != rst_at);
            wv = !(idx == stall_at && stall_seen < stall_len);
            wd = wv ? words[idx] : 8'($urandom);
            #1;
            rdy = sel ? if_b.word_ready : if_a.word_ready;
            en  = sel ? en_b   : en_a;
            cin = sel ? cin_b  : cin_a;
            cnr = sel ? cnr_b  : cnr_a;
            bsy = sel ? busy_b : busy_a;
            dn  = sel ? done_b : done_a;
            er  = sel ? err_b  : err_a;
            en_log[c] = en; cin_log[c] = cin; cnr_log[c] = cnr; done_log[c] = dn;
            if (c == rst_at + 1) begin
                chk("reset_mid_load_outputs", {rdy, cin, en, cnr, bsy, dn, er}, 0);
                break;
            end
            if (c > 0 && dn) begin
                done_cyc = c;
                err_at_done = er;
                chk("ready_in_done", {31'd0, rdy}, 0);
                break;
            end
            if (rdy) rdy_cnt++;
            if (en) en_cnt++;
            if (rdy && wv) begin
                if (hs_n < 8) hs_cyc[hs_n] = c;
                hs_n++;
                if (idx < 7) idx++;
            end else if (rdy) begin
                stall_seen++;
                if (en) stall_en++;
            end
            @(posedge clock); #1;
        end
        start_a = 1'b0; start_b = 1'b0; nreset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic finish_checks(input bit sel, input int len, input int stall, input bit exp_err);
        int ndw;
        ndw = (len + W - 1) / W;
        chk("enable_count", en_cnt, len);
        chk("done_cycle", done_cyc, 1 + CLR + ndw + len + stall + 2 * CRC_X);
        chk("ready_cycles", rdy_cnt, ndw + stall + CRC_X);
        chk("chain_contents", sel ? 32'(chain_b) : 32'(chain_a), stream_val(len));
        chk("error_flag", {31'd0, err_at_done}, {31'd0, exp_err});
    endtask

    initial begin
        logic [7:0] first_byte;
        nreset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_a", {if_a.word_ready, cin_a, en_a, cnr_a, busy_a, done_a, err_a}, 0);
        chk("reset_b", {if_b.word_ready, cin_b, en_b, cnr_b, busy_b, done_b, err_b}, 0);
        nreset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("idle_after_reset", {cnr_a, busy_a, done_a}, 3'b100);

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, -100, -1, -1);
        finish_checks(1'b0, LA, 0, 1'b0);
        chk("chain_directed", 32'(chain_a), 32'h0F3CA5);
        chk("clear_window", {cnr_log[1], cnr_log[2], cnr_log[3]}, 3'b001);
        chk("handshake_0", hs_cyc[0], 3);
        chk("handshake_1", hs_cyc[1], 12);
        chk("handshake_2", hs_cyc[2], 21);
        chk("enable_edges", {en_log[3], en_log[4], en_log[11], en_log[12], en_log[29]}, 5'b01101);
        for (int k = 0; k < 8; k++) first_byte[k] = cin_log[4 + k];
        chk("serial_first_word", first_byte, 8'hA5);

        run_load(1'b0, 1, 5, -100, -1, -1);
        finish_checks(1'b0, LA, 5, 1'b0);
        chk("stall_cycles", stall_seen, 5);
        chk("stall_enable_low", stall_en, 0);
        chk("chain_after_stall", 32'(chain_a), 32'h0F3CA5);

        for (int t = 0; t < 3; t++) begin
            rand_words();
            prep(LA, 1'b0);
            run_load(1'b0, (t == 1) ? 2 : -1, 3, -100, -1, -1);
            finish_checks(1'b0, LA, (t == 1) ? 3 : 0, 1'b0);
        end

        rand_words();
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, 15, -1, -1);
        rand_words();
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, -100, -1, -1);
        finish_checks(1'b0, LA, 0, 1'b0);

        rand_words();
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, -100, 6, 29);
        finish_checks(1'b0, LA, 0, 1'b0);
        rand_words();
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, -100, -1, -1);
        chk("reload_from_done", {done_log[0], done_log[1], cnr_log[1]}, 3'b100);
        finish_checks(1'b0, LA, 0, 1'b0);

        words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'hFF;
        prep(LB, 1'b0);
        run_load(1'b1, -1, 0, -100, -1, -1);
        finish_checks(1'b1, LB, 0, 1'b0);
        chk("partial_last_word", {en_log[22], en_log[25], en_log[26]}, 3'b110);
        rand_words();
        prep(LB, 1'b0);
        run_load(1'b1, -1, 0, -100, -1, -1);
        finish_checks(1'b1, LB, 0, 1'b0);

`ifdef CONFIG_LOADER_CRC_EN
        rand_words();
        prep(LA, 1'b0);
        run_load(1'b0, -1, 0, -100, -1, -1);
        finish_checks(1'b0, LA, 0, 1'b0);
        prep(LA, 1'b1);
        run_load(1'b0, -1, 0, -100, -1, -1);
        finish_checks(1'b0, LA, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
